blur_stream_ctrl: RTL and testbench

BLUR_STREAM_CTRL -- requirements
Module: blur_stream_ctrl

---
 rtl/blur_stream_ctrl_if.sv | 24 ++
 rtl/blur_stream_ctrl.sv | 72 +++++++
 tb/tb_blur_stream_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/blur_stream_ctrl_if.sv
// blur_stream_ctrl_if: stream handshake and blur-datapath control bundle
interface blur_stream_ctrl_if;
  logic        in_valid;
  logic        in_sop;
  logic        in_packet_video;
  logic        in_ready;
  logic        out_ready;
  logic        shift_en;
  logic        sel_blur;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic [10:0] x_count;
  logic [10:0] y_count;
  logic        short_frame;
  modport master (
    output in_valid, in_sop, in_packet_video, out_ready,
    input  in_ready, shift_en, sel_blur, out_valid, out_sop, out_eop, x_count, y_count, short_frame
  );
  modport slave (
    input  in_valid, in_sop, in_packet_video, out_ready,
    output in_ready, shift_en, sel_blur, out_valid, out_sop, out_eop, x_count, y_count, short_frame
  );
endinterface

// File: rtl/blur_stream_ctrl.sv
// blur_stream_ctrl: packet/line tracking and mux/shift control for a horizontal blur stream
module blur_stream_ctrl #(
  parameter int IMAGE_W = 640,
  parameter int IMAGE_H = 480,
  parameter int TAPS    = 4
) (
  input logic clk,
  input logic reset,
  blur_stream_ctrl_if.slave s
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CTRL  = 2'd1;
  localparam logic [1:0] VIDEO = 2'd2;
  localparam int FW = $clog2(TAPS + 1);
  logic [1:0]    state;
  logic [10:0]   px, py;
  logic [FW-1:0] fill, fill_nxt;
  logic          accept, pix, line_end, last;
  assign s.in_ready = s.out_ready | ~s.out_valid;
  assign accept     = s.in_valid & s.in_ready;
  assign pix        = accept & ~s.in_sop & (state == VIDEO);
  assign s.shift_en = pix & ~reset;
  assign line_end   = px == 11'(IMAGE_W - 1);
  assign last       = line_end & (py == 11'(IMAGE_H - 1));
  assign fill_nxt   = (fill == FW'(TAPS)) ? fill : fill + 1'b1;
  // px/py address the next pixel; x_count/y_count report the one just accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      px            <= '0;
      py            <= '0;
      fill          <= '0;
      s.x_count     <= '0;
      s.y_count     <= '0;
      s.out_valid   <= 1'b0;
      s.out_sop     <= 1'b0;
      s.out_eop     <= 1'b0;
      s.sel_blur    <= 1'b0;
      s.short_frame <= 1'b0;
    end else if (accept) begin
      s.short_frame <= s.in_sop & (state == VIDEO);
      if (s.in_sop) begin
        state       <= s.in_packet_video ? VIDEO : CTRL;
        px          <= '0;
        py          <= '0;
        fill        <= '0;
        s.x_count   <= '0;
        s.y_count   <= '0;
        s.out_valid <= 1'b1;
        s.out_sop   <= 1'b1;
        s.out_eop   <= 1'b0;
        s.sel_blur  <= 1'b0;
      end else begin
        s.out_valid <= state != IDLE;
        s.out_sop   <= 1'b0;
        s.out_eop   <= pix & last;
        s.sel_blur  <= pix & (fill_nxt == FW'(TAPS));
        if (pix) begin
          s.x_count <= last ? 11'd0 : px;
          s.y_count <= last ? 11'd0 : py;
          px        <= line_end ? 11'd0 : px + 11'd1;
          py        <= last ? 11'd0 : (line_end ? py + 11'd1 : py);
          fill      <= line_end ? '0 : fill_nxt;
          if (last) state <= IDLE;
        end
      end
    end else begin
      s.short_frame <= 1'b0;
      if (s.out_ready) s.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_blur_stream_ctrl.sv
// tb_blur_stream_ctrl: directed stimulus checked every cycle against a frame-position model
module tb_blur_stream_ctrl;
  localparam int W = 16;
  localparam int H = 4;
  localparam int T = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int shifts = 0;
  int blurs = 0;
  int eops = 0;
  blur_stream_ctrl_if bus ();
  blur_stream_ctrl #(.IMAGE_W(W), .IMAGE_H(H), .TAPS(T)) dut (.clk(clk), .reset(reset), .s(bus));
  always #5 clk = ~clk;
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: packet kind plus index of the next pixel within the frame
  int m_kind = 0;
  int m_n = 0;
  logic e_ov = 0, e_sop = 0, e_eop = 0, e_sel = 0, e_short = 0;
  int e_x = 0, e_y = 0;
  initial begin
    @(posedge clk);
    forever begin
      logic rdy, acc, sh;
      @(negedge clk);
      #3;
      rdy = bus.out_ready | ~e_ov;
      acc = bus.in_valid & rdy;
      sh  = !reset && acc && m_kind == 2 && !bus.in_sop;
      cmp("in_ready", bus.in_ready, rdy);
      cmp("shift_en", bus.shift_en, sh);
      cmp("out_valid", bus.out_valid, e_ov);
      if (e_ov) begin
        cmp("out_sop", bus.out_sop, e_sop);
        cmp("out_eop", bus.out_eop, e_eop);
        cmp("sel_blur", bus.sel_blur, e_sel);
      end
      cmp("x_count", bus.x_count, e_x);
      cmp("y_count", bus.y_count, e_y);
      cmp("short_frame", bus.short_frame, e_short);
      shifts += int'(bus.shift_en);
      if (bus.out_valid && bus.out_ready) begin
        blurs += int'(bus.sel_blur);
        eops  += int'(bus.out_eop);
      end
      if (reset) begin
        m_kind = 0; m_n = 0; e_ov = 0; e_sop = 0; e_eop = 0; e_sel = 0; e_short = 0; e_x = 0; e_y = 0;
      end else if (acc) begin
        e_short = bus.in_sop && m_kind == 2;
        if (bus.in_sop) begin
          m_kind = bus.in_packet_video ? 2 : 1;
          m_n = 0; e_x = 0; e_y = 0;
          e_ov = 1; e_sop = 1; e_eop = 0; e_sel = 0;
        end else begin
          e_sop = 0; e_eop = 0; e_sel = 0;
          e_ov = m_kind != 0;
          if (m_kind == 2) begin
            e_x = m_n % W;
            e_y = m_n / W;
            e_sel = e_x >= T - 1;
            e_eop = m_n == W * H - 1;
            m_n++;
            if (e_eop) begin
              m_kind = 0; m_n = 0; e_x = 0; e_y = 0;
            end
          end
        end
      end else begin
        e_short = 0;
        if (bus.out_ready) e_ov = 0;
      end
    end
  end
  task automatic send(input logic sop, input logic vid);
    logic acc = 0;
    @(negedge clk);
    bus.in_valid = 1; bus.in_sop = sop; bus.in_packet_video = vid;
    for (int k = 0; k < 20 && !acc; k++) begin
      if (k > 0) @(negedge clk);
      #3;
      acc = bus.in_ready;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: beat not accepted in 20 cycles at %0t", $time);
    end
  endtask
  task automatic idle();
    @(negedge clk);
    bus.in_valid = 0; bus.in_sop = 0;
    #4;
  endtask
  initial begin
    int sx, bx, ex;
    bus.in_valid = 0; bus.in_sop = 0; bus.in_packet_video = 0; bus.out_ready = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    #4;
    cmp("rst_out_valid", bus.out_valid, 0);
    cmp("rst_x", bus.x_count, 0);
    cmp("rst_short", bus.short_frame, 0);
    send(0, 1); send(0, 1); idle();
    cmp("idle_drop_valid", bus.out_valid, 0);
    cmp("idle_drop_shift", shifts, 0);
    sx = shifts; bx = blurs; ex = eops;
    send(1, 1); idle();
    cmp("vsop_out_sop", bus.out_sop, 1);
    for (int i = 0; i < 6; i++) begin
      send(0, 1); idle();
      cmp("first6_sel", bus.sel_blur, i >= 3);
    end
    cmp("first6_x", bus.x_count, 5);
    cmp("first6_shifts", shifts - sx, 6);
    send(0, 1);
    @(negedge clk);
    bus.out_ready = 0;
    #4;
    cmp("stall_in_ready", bus.in_ready, 0);
    sx = shifts;
    repeat (2) @(negedge clk);
    #4;
    cmp("stall_no_shift", shifts - sx, 0);
    cmp("stall_x_held", bus.x_count, 6);
    @(negedge clk);
    bus.out_ready = 1;
    #3;
    cmp("stall_release_acc", bus.in_ready, 1);
    idle();
    cmp("stall_x_after", bus.x_count, 7);
    for (int i = 8; i < W * H; i++) send(0, 1);
    idle();
    cmp("frame_eops", eops - ex, 1);
    cmp("frame_blurs", blurs - bx, (W - T + 1) * H);
    cmp("frame_end_x", bus.x_count, 0);
    send(0, 1); idle();
    cmp("after_frame_idle", bus.out_valid, 0);
    sx = shifts;
    send(1, 0);
    repeat (3) send(0, 0);
    idle();
    cmp("ctrl_valid", bus.out_valid, 1);
    cmp("ctrl_sel", bus.sel_blur, 0);
    cmp("ctrl_x", bus.x_count, 0);
    cmp("ctrl_shifts", shifts - sx, 0);
    send(1, 1);
    repeat (2 * W + 6) send(0, 1);
    idle();
    cmp("pre_short_x", bus.x_count, 5);
    cmp("pre_short_y", bus.y_count, 2);
    send(1, 1); idle();
    cmp("short_pulse", bus.short_frame, 1);
    cmp("short_x", bus.x_count, 0);
    cmp("short_y", bus.y_count, 0);
    idle();
    cmp("short_one_cycle", bus.short_frame, 0);
    sx = shifts;
    repeat (3) send(0, 1);
    idle();
    cmp("restart_video_shifts", shifts - sx, 3);
    cmp("restart_x", bus.x_count, 2);
    repeat (10) send(0, 1);
    @(negedge clk);
    reset = 1; bus.in_valid = 1; bus.in_sop = 0;
    @(negedge clk);
    reset = 0;
    #4;
    cmp("midrst_valid", bus.out_valid, 0);
    cmp("midrst_x", bus.x_count, 0);
    cmp("midrst_eop", bus.out_eop, 0);
    sx = shifts;
    send(0, 1); send(0, 1); idle();
    cmp("midrst_ignored", shifts - sx, 0);
    cmp("midrst_no_out", bus.out_valid, 0);
    send(1, 1); send(0, 1); idle();
    cmp("post_rst_valid", bus.out_valid, 1);
    cmp("post_rst_sel", bus.sel_blur, 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
